// File: rtl/sobel_gradient_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_gradient_pipe_if                                          |
// | Brief    : Window-in / gradient-out handshake bundle for the Sobel pipe.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sobel_gradient_pipe_if #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 32
);
    localparam int GW = DATA_W + 3;

    logic                  in_valid;
    logic                  in_ready;
    logic [9*DATA_W-1:0]   in_win;
    logic                  in_last;
    logic [1:0]            mode;
    logic [GW-1:0]         threshold;
    logic                  cnt_clear;
    logic                  out_valid;
    logic                  out_ready;
    logic [GW-1:0]         out_gx;
    logic [GW-1:0]         out_gy;
    logic [GW-1:0]         out_mag;
    logic [DATA_W-1:0]     out_pix;
    logic                  out_edge;
    logic                  out_last;
    logic [CNT_W-1:0]      edge_count;

    modport master (
        output in_valid, in_win, in_last, mode, threshold, cnt_clear, out_ready,
        input  in_ready, out_valid, out_gx, out_gy, out_mag, out_pix, out_edge,
               out_last, edge_count
    );

    modport slave (
        input  in_valid, in_win, in_last, mode, threshold, cnt_clear, out_ready,
        output in_ready, out_valid, out_gx, out_gy, out_mag, out_pix, out_edge,
               out_last, edge_count
    );
endinterface
`default_nettype wire

// File: rtl/sobel_gradient_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sobel_gradient_pipe                                             |
// | Brief    : 3-stage Sobel gradient/magnitude pipeline with edge counting.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sobel_gradient_pipe #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sobel_gradient_pipe_if.slave    bus
);
    localparam int GW = DATA_W + 3;
    localparam int SW = DATA_W + 2;

    logic [DATA_W-1:0] w_p [9];

    generate
        for (genvar k = 0; k < 9; k++) begin : g_pix
            assign w_p[k] = bus.in_win[k*DATA_W +: DATA_W];
        end
    endgenerate

    logic [SW-1:0] w_right, w_left, w_bot, w_top;
    assign w_right = {2'b00, w_p[2]} + {1'b0, w_p[5], 1'b0} + {2'b00, w_p[8]};
    assign w_left  = {2'b00, w_p[0]} + {1'b0, w_p[3], 1'b0} + {2'b00, w_p[6]};
    assign w_bot   = {2'b00, w_p[6]} + {1'b0, w_p[7], 1'b0} + {2'b00, w_p[8]};
    assign w_top   = {2'b00, w_p[0]} + {1'b0, w_p[1], 1'b0} + {2'b00, w_p[2]};

    logic                r_s1_valid, r_s2_valid, r_s3_valid, r_rdy_en;
    logic [SW-1:0]       r_s1_right, r_s1_left, r_s1_bot, r_s1_top;
    logic [1:0]          r_s1_mode, r_s2_mode;
    logic [GW-1:0]       r_s1_thr, r_s2_thr;
    logic                r_s1_last, r_s2_last, r_s3_last;
    logic signed [GW-1:0] r_s2_gx, r_s2_gy;
    logic [GW-1:0]       r_s3_gx, r_s3_gy, r_s3_mag;
    logic [DATA_W-1:0]   r_s3_pix;
    logic                r_s3_edge;
    logic [CNT_W-1:0]    r_cnt;

    // A stage may move forward whenever its successor is empty or moving, so bubbles collapse.
    logic w_adv1, w_adv2, w_adv3, w_in_ready, w_in_fire, w_out_fire;
    assign w_adv3     = !r_s3_valid || bus.out_ready;
    assign w_adv2     = w_adv3 || !r_s2_valid;
    assign w_adv1     = w_adv2 || !r_s1_valid;
    assign w_in_ready = r_rdy_en && !(r_s3_valid && !bus.out_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_s3_valid && bus.out_ready;

    function automatic logic [DATA_W-1:0] f_sat(input logic [GW-1:0] x);
        f_sat = (|x[GW-1:DATA_W]) ? {DATA_W{1'b1}} : x[DATA_W-1:0];
    endfunction

    logic [GW-1:0]     w_abs_gx, w_abs_gy, w_mag;
    logic              w_edge;
    logic [DATA_W-1:0] w_pix;
    assign w_abs_gx = r_s2_gx[GW-1] ? $unsigned(-r_s2_gx) : $unsigned(r_s2_gx);
    assign w_abs_gy = r_s2_gy[GW-1] ? $unsigned(-r_s2_gy) : $unsigned(r_s2_gy);
    assign w_mag    = w_abs_gx + w_abs_gy;
    assign w_edge   = (w_mag >= r_s2_thr);

    always_comb begin
        w_pix = '0;
        case (r_s2_mode)
            2'd0:    w_pix = f_sat(w_abs_gx);
            2'd1:    w_pix = f_sat(w_abs_gy);
            2'd2:    w_pix = f_sat(w_mag);
            default: w_pix = w_edge ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_right <= '0;
            r_s1_left  <= '0;
            r_s1_bot   <= '0;
            r_s1_top   <= '0;
            r_s1_mode  <= '0;
            r_s1_thr   <= '0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_gx    <= '0;
            r_s2_gy    <= '0;
            r_s2_mode  <= '0;
            r_s2_thr   <= '0;
            r_s2_last  <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_gx    <= '0;
            r_s3_gy    <= '0;
            r_s3_mag   <= '0;
            r_s3_pix   <= '0;
            r_s3_edge  <= 1'b0;
            r_s3_last  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_adv1) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_right <= w_right;
                    r_s1_left  <= w_left;
                    r_s1_bot   <= w_bot;
                    r_s1_top   <= w_top;
                    r_s1_mode  <= bus.mode;
                    r_s1_thr   <= bus.threshold;
                    r_s1_last  <= bus.in_last;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_gx   <= $signed({1'b0, r_s1_right}) - $signed({1'b0, r_s1_left});
                    r_s2_gy   <= $signed({1'b0, r_s1_bot}) - $signed({1'b0, r_s1_top});
                    r_s2_mode <= r_s1_mode;
                    r_s2_thr  <= r_s1_thr;
                    r_s2_last <= r_s1_last;
                end
            end
            if (w_adv3) begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_s3_gx   <= $unsigned(r_s2_gx);
                    r_s3_gy   <= $unsigned(r_s2_gy);
                    r_s3_mag  <= w_mag;
                    r_s3_pix  <= w_pix;
                    r_s3_edge <= w_edge;
                    r_s3_last <= r_s2_last;
                end
            end
            // Clear wins over a same-cycle edge so that edge is dropped.
            if (bus.cnt_clear)
                r_cnt <= '0;
            else if (w_out_fire && r_s3_edge)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s3_valid;
    assign bus.out_gx     = r_s3_valid ? r_s3_gx   : '0;
    assign bus.out_gy     = r_s3_valid ? r_s3_gy   : '0;
    assign bus.out_mag    = r_s3_valid ? r_s3_mag  : '0;
    assign bus.out_pix    = r_s3_valid ? r_s3_pix  : '0;
    assign bus.out_edge   = r_s3_valid && r_s3_edge;
    assign bus.out_last   = r_s3_valid && r_s3_last;
    assign bus.edge_count = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sobel_gradient_pipe                                          |
// | Brief    : Self-checking bench for sobel_gradient_pipe (DATA_W=8,CNT_W=4). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sobel_gradient_pipe;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int GW = DW + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_gradient_pipe_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    sobel_gradient_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int gx; int gy; int mag; int pix; int edg; int last;
    } exp_t;

    exp_t q[$];
    int   model_cnt = 0;
    int   tests     = 0;
    int   fails     = 0;
    int   n_out     = 0;
    bit   acc       = 1'b0;

    function automatic int px(input logic [9*DW-1:0] w, input int r, input int c);
        return int'(w[(3*r+c)*DW +: DW]);
    endfunction

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Reference: plain integer Sobel from the pixel definition.
    function automatic exp_t model(input logic [9*DW-1:0] w, input int md, input int thr, input int lst);
        exp_t e;
        int ax, ay;
        e.gx  = (px(w,0,2) + 2*px(w,1,2) + px(w,2,2)) - (px(w,0,0) + 2*px(w,1,0) + px(w,2,0));
        e.gy  = (px(w,2,0) + 2*px(w,2,1) + px(w,2,2)) - (px(w,0,0) + 2*px(w,0,1) + px(w,0,2));
        ax    = (e.gx < 0) ? -e.gx : e.gx;
        ay    = (e.gy < 0) ? -e.gy : e.gy;
        e.mag = ax + ay;
        e.edg = (e.mag >= thr) ? 1 : 0;
        case (md)
            0:       e.pix = sat(ax);
            1:       e.pix = sat(ay);
            2:       e.pix = sat(e.mag);
            default: e.pix = e.edg ? 255 : 0;
        endcase
        e.last = lst;
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, score, then advance past posedge.
    task automatic step();
        exp_t e;
        bit   xfer;
        @(negedge clk);
        xfer = 1'b0;
        chk("edge_count", int'(bus.edge_count), model_cnt);
        chk("in_ready", int'(bus.in_ready), (bus.out_valid && !bus.out_ready) ? 0 : 1);
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", int'(bus.out_valid), 0);
            end else begin
                e = q[0];
                chk("out_gx",   int'($signed(bus.out_gx)), e.gx);
                chk("out_gy",   int'($signed(bus.out_gy)), e.gy);
                chk("out_mag",  int'(bus.out_mag),  e.mag);
                chk("out_pix",  int'(bus.out_pix),  e.pix);
                chk("out_edge", int'(bus.out_edge), e.edg);
                chk("out_last", int'(bus.out_last), e.last);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                    xfer = 1'b1;
                end
            end
        end else begin
            chk("idle_zero", int'({bus.out_gx, bus.out_gy, bus.out_mag, bus.out_pix,
                                   bus.out_edge, bus.out_last} != '0), 0);
        end
        if (bus.cnt_clear)
            model_cnt = 0;
        else if (xfer && e.edg == 1)
            model_cnt = (model_cnt + 1) % (1 << CW);
        acc = bus.in_valid && bus.in_ready;
        if (acc)
            q.push_back(model(bus.in_win, int'(bus.mode), int'(bus.threshold), int'(bus.in_last)));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9*DW-1:0] w, input int md, input int thr, input bit lst);
        bus.in_valid  = 1'b1;
        bus.in_win    = w;
        bus.mode      = 2'(md);
        bus.threshold = GW'(thr);
        bus.in_last   = lst;
    endtask

    function automatic logic [9*DW-1:0] rand_win();
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    task automatic run_one(input logic [9*DW-1:0] w, input int md, input int thr, input bit lst, output int lat);
        drive(w, md, thr, lst);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", lat, 3);
    endtask

    // n windows back-to-back; thr<0 picks random thresholds; stall drops out_ready in cycles 4-7.
    task automatic burst(input int n, input int thr, input bit stall);
        int sent = 0;
        int c    = 0;
        int n0   = n_out;
        while ((sent < n || q.size() != 0) && c < 80) begin
            bus.out_ready = !(stall && c >= 4 && c <= 7);
            if (sent < n)
                drive(rand_win(), int'($urandom_range(0, 3)),
                      (thr < 0) ? int'($urandom_range(0, 2047)) : thr, sent % 3 == 0);
            else
                bus.in_valid = 1'b0;
            step();
            if (acc) sent++;
            c++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("burst_count", n_out - n0, n);
        chk("burst_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9*DW-1:0] w;
        int lat;
        bus.in_valid = 1'b0; bus.in_win = '0; bus.in_last = 1'b0; bus.mode = 2'd0;
        bus.threshold = '0; bus.cnt_clear = 1'b0; bus.out_ready = 1'b1;

        #1;
        chk("rst_out_valid",  int'(bus.out_valid), 0);
        chk("rst_in_ready",   int'(bus.in_ready), 0);
        chk("rst_edge_count", int'(bus.edge_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", int'(bus.in_ready), 1);

        // Flat window
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = 8'd100;
        run_one(w, 2, 50, 1'b0, lat);
        chk("flat_gx",   int'($signed(bus.out_gx)), 0);
        chk("flat_mag",  int'(bus.out_mag), 0);
        chk("flat_pix",  int'(bus.out_pix), 0);
        chk("flat_edge", int'(bus.out_edge), 0);
        step();

        // Vertical edge, saturating |gx|
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*DW +: DW] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255;
        run_one(w, 0, 2047, 1'b1, lat);
        chk("vert_gx",  int'($signed(bus.out_gx)), 1020);
        chk("vert_gy",  int'($signed(bus.out_gy)), 0);
        chk("vert_mag", int'(bus.out_mag), 1020);
        chk("vert_pix", int'(bus.out_pix), 255);
        step();

        // Horizontal edge at threshold equality
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*DW +: DW] = (r == 0) ? 8'd255 : 8'd0;
        run_one(w, 1, 1020, 1'b0, lat);
        chk("horz_gy",   int'($signed(bus.out_gy)), -1020);
        chk("horz_mag",  int'(bus.out_mag), 1020);
        chk("horz_edge", int'(bus.out_edge), 1);
        step();
        chk("horz_count", int'(bus.edge_count), 1);

        burst(10, -1, 1'b1);

        // Random traffic with bubbles, backpressure and occasional clears
        for (int i = 0; i < 150; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.cnt_clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 7)
                drive(rand_win(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
                      1'($urandom));
            else
                bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b0; bus.cnt_clear = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) step();
        chk("random_drained", q.size(), 0);

        // Reset with two windows in flight
        drive(rand_win(), 2, 0, 1'b1);
        step();
        drive(rand_win(), 2, 0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("inflight_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(bus.out_valid), 0);
        chk("async_outputs",   int'({bus.out_gx, bus.out_gy, bus.out_mag, bus.out_pix,
                                     bus.out_edge, bus.out_last} != '0), 0);
        chk("async_count",     int'(bus.edge_count), 0);
        chk("async_in_ready",  int'(bus.in_ready), 0);
        q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", int'(bus.in_ready), 1);
        for (int i = 0; i < 6; i++) step();

        // Counter wrap and clear priority
        burst(15, 0, 1'b0);
        chk("count_15", int'(bus.edge_count), 15);
        run_one(rand_win(), 3, 0, 1'b0, lat);
        step();
        chk("count_wrap", int'(bus.edge_count), 0);
        burst(3, 0, 1'b0);
        chk("count_3", int'(bus.edge_count), 3);
        run_one(rand_win(), 3, 0, 1'b0, lat);
        bus.cnt_clear = 1'b1;
        step();
        bus.cnt_clear = 1'b0;
        chk("clear_priority", int'(bus.edge_count), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
